sseg_scan_ctrl: RTL

//  Scan controller for the 8-digit seven-segment display. It owns the refresh timebase and the

---
 rtl/sseg_pkg.sv | 17 +
 rtl/scan_tick_gen.sv | 25 ++
 rtl/sseg_scan_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants, load-FSM encoding and blanking helper for the seven-segment scan path.
package sseg_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [7:0] ANODE_OFF  = 8'hFF;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } load_state_t;

   // A digit above 0 is a leading zero when every nibble from it upward is zero.
   function automatic logic lz_blank(input logic [31:0] value, input logic [2:0] digit);
      return (digit != 3'd0) && ((value >> {digit, 2'b00}) == 32'd0);
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh timebase: free-running divider that flags the last cycle of each digit slot.
module scan_tick_gen #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] div_cnt;

   assign tick = (div_cnt == CW'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + CW'(1);
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit display scanner with dead time, leading-zero blanking and a
// double-buffered value load that only commits on the 7->0 digit wrap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no value waiting; shown is current
//   PENDING | value captured in pending, committed at next frame boundary
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYC    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] value_in,
   input  logic        load,
   input  logic        lz_en,
   output logic        busy,
   output logic        frame_start,
   output logic [2:0]  digit_sel,
   output logic [3:0]  hex_out,
   output logic [7:0]  anode
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

   load_state_t   state;
   logic          tick;
   logic [2:0]    digit;
   logic [2:0]    digit_nxt;
   logic [CW-1:0] dead_cnt;
   logic [CW-1:0] dead_nxt;
   logic [31:0]   shown;
   logic [31:0]   shown_nxt;
   logic [31:0]   pending;
   logic          commit;

   scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   always_comb begin
      digit_nxt = tick ? digit + 3'd1 : digit;
      if (tick)
         dead_nxt = CW'(DEAD_CYC);
      else if (dead_cnt != '0)
         dead_nxt = dead_cnt - CW'(1);
      else
         dead_nxt = dead_cnt;
      commit    = (state == PENDING) && tick && (digit == LAST_DIGIT);
      shown_nxt = commit ? pending : shown;
   end

   assign digit_sel = digit;

   // Outputs are built from next-state values so they line up with digit/dead_cnt.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         digit       <= 3'd0;
         dead_cnt    <= CW'(DEAD_CYC);
         shown       <= 32'd0;
         pending     <= 32'd0;
         busy        <= 1'b0;
         frame_start <= 1'b0;
         hex_out     <= 4'd0;
         anode       <= ANODE_OFF;
      end else begin
         digit    <= digit_nxt;
         dead_cnt <= dead_nxt;
         shown    <= shown_nxt;
         case (state)
            IDLE: begin
               if (load) begin
                  pending <= value_in;
                  busy    <= 1'b1;
                  state   <= PENDING;
               end
            end
            PENDING: begin
               if (load)
                  pending <= value_in;
               if (commit && !load) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         frame_start <= tick && (digit == LAST_DIGIT);
         hex_out     <= shown_nxt[{digit_nxt, 2'b00} +: 4];
         if ((dead_nxt != '0) || (lz_en && lz_blank(shown_nxt, digit_nxt)))
            anode <= ANODE_OFF;
         else
            anode <= ~(8'b1 << digit_nxt);
      end
   end

endmodule
